// File: rtl/fip_32_sqrt_iter.sv
// rtl/fip_32_sqrt_iter.sv - iterative unsigned fixed-point square root, one root bit per clock
module fip_32_sqrt_iter #(
  parameter int FRA_BITS = 16
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_en,
  input  logic [31:0] i_rad,
  output logic        o_ready,
  output logic [31:0] o_root,
  output logic        o_valid
);

  localparam int ROOT_BITS = (32 + FRA_BITS) / 2;
  localparam int OP_BITS   = 32 + FRA_BITS;
  localparam int CNT_BITS  = $clog2(ROOT_BITS);
  localparam logic [CNT_BITS-1:0] LAST_ITER = CNT_BITS'(ROOT_BITS - 1);

  // An odd fractional width has no exact half-width root format.
  generate
    if ((FRA_BITS % 2) != 0) begin : g_bad_fra_bits
      $error("fip_32_sqrt_iter: FRA_BITS must be even");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t               state;
  logic [OP_BITS-1:0]   op;
  logic [ROOT_BITS+1:0] r;
  logic [ROOT_BITS-1:0] q;
  logic [CNT_BITS-1:0]  cnt;

  logic [ROOT_BITS+3:0] trial;
  logic [ROOT_BITS+3:0] diff;
  logic                 keep;
  logic [ROOT_BITS+1:0] r_next;
  logic [ROOT_BITS-1:0] q_next;
  logic                 unused_trial_hi;

  // One restoring step: bring down two radicand bits and try to subtract (4q+1).
  always_comb begin
    trial  = {r, op[OP_BITS-1 -: 2]};
    diff   = trial - {2'b00, q, 2'b01};
    keep   = ~diff[ROOT_BITS+3];
    r_next = keep ? diff[ROOT_BITS+1:0] : trial[ROOT_BITS+1:0];
    q_next = {q[ROOT_BITS-2:0], keep};
  end

  // Upper trial bits stay zero for every remainder the recurrence can produce.
  assign unused_trial_hi = ^{trial[ROOT_BITS+3:ROOT_BITS+2], diff[ROOT_BITS+2]};

  // Request handshake, iteration sequencing and registered result.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state   <= S_IDLE;
      op      <= '0;
      r       <= '0;
      q       <= '0;
      cnt     <= '0;
      o_ready <= 1'b1;
      o_valid <= 1'b0;
      o_root  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_en) begin
            op      <= {i_rad, {FRA_BITS{1'b0}}};
            r       <= '0;
            q       <= '0;
            cnt     <= '0;
            o_ready <= 1'b0;
            state   <= S_CALC;
          end
        end
        S_CALC: begin
          r   <= r_next;
          q   <= q_next;
          op  <= {op[OP_BITS-3:0], 2'b00};
          cnt <= cnt + CNT_BITS'(1);
          if (cnt == LAST_ITER) begin
            o_root  <= 32'(q_next);
            o_valid <= 1'b1;
            state   <= S_DONE;
          end
        end
        S_DONE: begin
          o_valid <= 1'b0;
          o_ready <= 1'b1;
          state   <= S_IDLE;
        end
        default: begin
          o_valid <= 1'b0;
          o_ready <= 1'b1;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fip_32_sqrt_iter.sv
// tb/tb_fip_32_sqrt_iter.sv - self-checking bench for fip_32_sqrt_iter
module tb_fip_32_sqrt_iter;

  localparam int ROOT_BITS = 24;
  localparam int N_RANDOM  = 1500;

  logic        i_clk;
  logic        i_rstn;
  logic        i_en;
  logic [31:0] i_rad;
  logic        o_ready;
  logic [31:0] o_root;
  logic        o_valid;

  int pass_cnt = 0;
  int total_cnt = 0;

  fip_32_sqrt_iter #(.FRA_BITS(16)) dut (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .i_en    (i_en),
    .i_rad   (i_rad),
    .o_ready (o_ready),
    .o_root  (o_root),
    .o_valid (o_valid)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (ok) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Largest r with r*r <= x, by binary search.
  function automatic logic [63:0] isqrt(input logic [63:0] x);
    logic [63:0] lo, hi, mid;
    lo = 0;
    hi = 64'd1 << 24;
    while (lo < hi) begin
      mid = (lo + hi + 1) >> 1;
      if (mid * mid <= x) lo = mid;
      else hi = mid - 1;
    end
    return lo;
  endfunction

  // Reference model: request accepted when idle, result due ROOT_BITS edges later.
  bit          model_ok = 0;
  bit          m_busy;
  int          m_age;
  logic [31:0] m_rad;
  logic        exp_ready;
  logic        exp_valid;
  logic [31:0] exp_root;

  always @(posedge i_clk) begin
    if (!i_rstn) begin
      m_busy    = 0;
      m_age     = 0;
      exp_ready = 1'b1;
      exp_valid = 1'b0;
      exp_root  = 32'h0;
      model_ok  = 1;
    end else if (m_busy) begin
      m_age++;
      if (m_age == ROOT_BITS) begin
        exp_valid = 1'b1;
        exp_root  = 32'(isqrt({16'h0, m_rad, 16'h0}));
      end else if (m_age == ROOT_BITS + 1) begin
        m_busy    = 0;
        exp_valid = 1'b0;
        exp_ready = 1'b1;
      end
    end else if (i_en) begin
      m_busy    = 1;
      m_age     = 0;
      m_rad     = i_rad;
      exp_ready = 1'b0;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge i_clk) begin
    if (model_ok) begin
      check(o_ready == exp_ready, "ready", 64'(o_ready), 64'(exp_ready));
      check(o_valid == exp_valid, "valid", 64'(o_valid), 64'(exp_valid));
      check(o_root == exp_root, "root", 64'(o_root), 64'(exp_root));
      if (o_valid && exp_valid) begin
        logic [63:0] x, rr;
        x  = {16'h0, m_rad, 16'h0};
        rr = {32'h0, o_root};
        check((rr * rr <= x) && ((rr + 1) * (rr + 1) > x), "root_bracket", rr, x);
      end
    end
  end

  task automatic issue(input logic [31:0] rad, input string name);
    int k;
    for (k = 0; k < 40 && !o_ready; k++) begin
      @(posedge i_clk);
      #1;
    end
    if (!o_ready) check(1'b0, {name, "_ready_timeout"}, 64'(o_ready), 64'd1);
    i_en  = 1'b1;
    i_rad = rad;
    @(posedge i_clk);
    #1;
    i_en = 1'b0;
  endtask

  task automatic wait_valid(input logic [31:0] exp, input string name, input bit noisy);
    int k;
    bit seen;
    seen = 0;
    for (k = 1; k <= 40; k++) begin
      if (noisy) begin
        i_en  = 1'($urandom);
        i_rad = $urandom;
      end
      @(posedge i_clk);
      #1;
      if (o_valid) begin
        seen = 1;
        break;
      end
    end
    i_en = 1'b0;
    if (!seen) begin
      check(1'b0, {name, "_valid_timeout"}, 64'd0, 64'd1);
    end else begin
      check(k == ROOT_BITS, {name, "_latency"}, 64'(k), 64'(ROOT_BITS));
      if (!noisy) check(o_root == exp, name, 64'(o_root), 64'(exp));
    end
  endtask

  initial begin
    logic [31:0] rad;
    int seen_valid;

    i_rstn = 1'b0;
    i_en   = 1'b0;
    i_rad  = 32'h0;
    repeat (2) @(posedge i_clk);
    #1;
    check(o_ready == 1'b1, "reset_ready", 64'(o_ready), 64'd1);
    check(o_valid == 1'b0, "reset_valid", 64'(o_valid), 64'd0);
    check(o_root == 32'h0, "reset_root", 64'(o_root), 64'd0);
    i_rstn = 1'b1;

    issue(32'h0001_0000, "sq1");  wait_valid(32'h0001_0000, "sq1", 0);
    issue(32'h0004_0000, "sq4");  wait_valid(32'h0002_0000, "sq4", 0);
    issue(32'h0009_0000, "sq9");  wait_valid(32'h0003_0000, "sq9", 0);
    issue(32'h0002_0000, "sqrt2"); wait_valid(32'h0001_6A09, "sqrt2", 0);
    issue(32'h0000_0001, "lsb");  wait_valid(32'h0000_0100, "lsb", 0);
    issue(32'h0000_0000, "zero"); wait_valid(32'h0000_0000, "zero", 0);
    issue(32'hFFFF_FFFF, "max");  wait_valid(32'h00FF_FFFF, "max", 0);

    // i_en held high through the computation; second accept lands on E26.
    issue(32'h0000_0000, "busy_pre"); wait_valid(32'h0, "busy_pre", 0);
    @(posedge i_clk); #1;
    i_en  = 1'b1;
    i_rad = 32'h0004_0000;
    @(posedge i_clk); #1;
    i_rad = 32'h0009_0000;
    wait_valid(32'h0002_0000, "busy_first", 0);
    i_en = 1'b1;
    @(posedge i_clk); #1;
    check(o_ready == 1'b1, "busy_ready_e25", 64'(o_ready), 64'd1);
    @(posedge i_clk); #1;
    check(o_ready == 1'b0, "busy_accept_e26", 64'(o_ready), 64'd0);
    i_en = 1'b0;
    wait_valid(32'h0003_0000, "busy_second", 0);

    // Reset after iteration 10 aborts the computation.
    issue(32'h0001_0000, "abort");
    repeat (10) @(posedge i_clk);
    #1;
    i_rstn = 1'b0;
    @(posedge i_clk); #1;
    i_rstn = 1'b1;
    check(o_ready == 1'b1, "abort_ready", 64'(o_ready), 64'd1);
    check(o_valid == 1'b0, "abort_valid", 64'(o_valid), 64'd0);
    check(o_root == 32'h0, "abort_root", 64'(o_root), 64'd0);
    seen_valid = 0;
    repeat (30) begin
      @(posedge i_clk); #1;
      if (o_valid) seen_valid++;
    end
    check(seen_valid == 0, "abort_no_valid", 64'(seen_valid), 64'd0);
    issue(32'h0009_0000, "after_abort"); wait_valid(32'h0003_0000, "after_abort", 0);

    // Idle hold: result stays, no further pulses.
    seen_valid = 0;
    repeat (100) begin
      @(posedge i_clk); #1;
      if (o_valid) seen_valid++;
    end
    check(seen_valid == 0, "hold_no_valid", 64'(seen_valid), 64'd0);
    check(o_root == 32'h0003_0000, "hold_root", 64'(o_root), 64'h30000);

    // Random radicands with noisy i_en/i_rad while busy; checked by the model.
    for (int n = 0; n < N_RANDOM; n++) begin
      case ($urandom % 4)
        0: rad = $urandom;
        1: rad = $urandom % 32'h0001_0000;
        2: rad = 32'hFFFF_0000 | ($urandom % 32'h0001_0000);
        default: rad = $urandom >> ($urandom % 32);
      endcase
      issue(rad, "rand");
      wait_valid(32'h0, "rand", 1);
    end
    repeat (3) @(posedge i_clk);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
